// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shifter: operation encoding and controller states.
package shifter_pkg;
   typedef enum logic [1:0] {
      SH_ROR = 2'b00,
      SH_LSL = 2'b01,
      SH_LSR = 2'b10,
      SH_ASR = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sh_state_t;
endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP positions, with the last bit shifted out.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] value,
   input  shift_op_t        op,
   input  logic [AMT_W-1:0] k,
   output logic [WIDTH-1:0] shifted,
   output logic             carry
);
   logic [AMT_W-1:0] kk;
   logic [AMT_W:0]   hi_amt;
   logic [WIDTH-1:0] lo_bits;
   logic [WIDTH-1:0] hi_bits;

   always_comb begin
      kk      = (k > AMT_W'(STEP)) ? AMT_W'(STEP) : k;
      hi_amt  = (AMT_W+1)'(WIDTH) - {1'b0, kk};
      // bit 0 of these holds working[k-1] and working[WIDTH-k] respectively
      lo_bits = value >> (kk - 1'b1);
      hi_bits = value >> hi_amt;
      shifted = value;
      carry   = 1'b0;
      if (kk != '0) begin
         case (op)
            SH_LSL: begin
               shifted = value << kk;
               carry   = hi_bits[0];
            end
            SH_LSR: begin
               shifted = value >> kk;
               carry   = lo_bits[0];
            end
            SH_ASR: begin
               shifted = WIDTH'($signed(value) >>> kk);
               carry   = lo_bits[0];
            end
            default: begin
               shifted = (value >> kk) | (value << hi_amt);
               carry   = lo_bits[0];
            end
         endcase
      end
   end
endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle valid/ready shifter (ROR/LSL/LSR/ASR), STEP positions per cycle.
// Define SHIFTER_CARRY_EN to add the out_carry port and its carry register.
module seq_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH),
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SHIFTER_CARRY_EN
   output logic             out_carry,
`endif
   output logic [WIDTH-1:0] out_data
);
   sh_state_t        state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   shift_op_t        op_q, op_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] k;
   logic [WIDTH-1:0] step_val;
`ifdef SHIFTER_CARRY_EN
   logic             carry_q, carry_d;
   logic             step_carry;
`else
   logic             carry_unused;
`endif

   assign k = (rem_q > AMT_W'(STEP)) ? AMT_W'(STEP) : rem_q;

   shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AMT_W(AMT_W)) u_step (
      .value   (work_q),
      .op      (op_q),
      .k       (rem_q),
      .shifted (step_val),
`ifdef SHIFTER_CARRY_EN
      .carry   (step_carry)
`else
      .carry   (carry_unused)
`endif
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      op_d    = op_q;
      rem_d   = rem_q;
`ifdef SHIFTER_CARRY_EN
      carry_d = carry_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            work_d  = in_data;
            op_d    = shift_op_t'(in_op);
            rem_d   = in_amt;
`ifdef SHIFTER_CARRY_EN
            carry_d = 1'b0;
`endif
            state_d = (in_amt == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            work_d  = step_val;
`ifdef SHIFTER_CARRY_EN
            carry_d = step_carry;
`endif
            rem_d   = rem_q - k;
            if (rem_q == k) state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         op_q    <= SH_ROR;
         rem_q   <= '0;
`ifdef SHIFTER_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
`ifdef SHIFTER_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = work_q;
`ifdef SHIFTER_CARRY_EN
   assign out_carry = carry_q;
`endif
endmodule

// File: tb/tb_seq_shifter.sv
// Randomized bench for seq_shifter: one STEP=1 and one STEP=4 instance against a bit-serial model.
module tb_seq_shifter;
   logic        clk;
   logic        reset;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [15:0] in_data   [2];
   logic [1:0]  in_op     [2];
   logic [3:0]  in_amt    [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] out_data  [2];
`ifdef SHIFTER_CARRY_EN
   logic        out_carry [2];
`endif
   int          stp [2] = '{1, 4};
   int          n_checks = 0;
   int          n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_shifter #(.WIDTH(16), .STEP(1)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_op(in_op[0]), .in_amt(in_amt[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
`ifdef SHIFTER_CARRY_EN
      .out_carry(out_carry[0]),
`endif
      .out_data(out_data[0]));

   seq_shifter #(.WIDTH(16), .STEP(4)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_op(in_op[1]), .in_amt(in_amt[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
`ifdef SHIFTER_CARRY_EN
      .out_carry(out_carry[1]),
`endif
      .out_data(out_data[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: amt single-position shifts; carry is the bit dropped by the final one.
   function automatic void model(input logic [15:0] d, input logic [1:0] op, input int amt,
                                 output logic [15:0] r, output logic c);
      r = d;
      c = 1'b0;
      for (int i = 0; i < amt; i++) begin
         case (op)
            2'b01: begin c = r[15]; r = {r[14:0], 1'b0}; end
            2'b10: begin c = r[0];  r = {1'b0, r[15:1]}; end
            2'b11: begin c = r[0];  r = {r[15], r[15:1]}; end
            default: begin c = r[0]; r = {r[0], r[15:1]}; end
         endcase
      end
   endfunction

   task automatic run_op(input int d, input logic [15:0] data, input logic [1:0] op,
                         input int amt, input int hold);
      logic [15:0] er, od;
      logic        ec;
      int          lat, n;
      model(data, op, amt, er, ec);
      n = 0;
      @(negedge clk);
      while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
      check("in_ready_wait", in_ready[d], 1);
      in_valid[d] = 1'b1; in_data[d] = data; in_op[d] = op; in_amt[d] = 4'(amt);
      @(negedge clk);
      in_valid[d] = 1'b0; in_data[d] = 16'($urandom); in_op[d] = 2'($urandom);
      lat = 1;
      check("busy_in_ready", in_ready[d], 0);
      while (!out_valid[d] && lat < 50) begin @(negedge clk); lat++; end
      check("latency", lat, 1 + (amt + stp[d] - 1) / stp[d]);
      check("data", out_data[d], er);
`ifdef SHIFTER_CARRY_EN
      check("carry", out_carry[d], ec);
`endif
      od = out_data[d];
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = 1'b1; in_data[d] = 16'($urandom); in_amt[d] = 4'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid[d], 1);
         check("hold_data", out_data[d], od);
         check("hold_in_ready", in_ready[d], 0);
`ifdef SHIFTER_CARRY_EN
         check("hold_carry", out_carry[d], ec);
`endif
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0; in_valid[d] = 1'b0;
      check("rel_in_ready", in_ready[d], 1);
      check("rel_valid", out_valid[d], 0);
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; in_data[d] = '0; in_op[d] = '0; in_amt[d] = '0; out_ready[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", in_ready[d], 1);
         check("rst_out_valid", out_valid[d], 0);
         check("rst_out_data", out_data[d], 0);
`ifdef SHIFTER_CARRY_EN
         check("rst_carry", out_carry[d], 0);
`endif
      end
      reset = 1'b0;

      run_op(0, 16'h8001, 2'b01, 1, 0);
      run_op(0, 16'h00F0, 2'b10, 5, 0);
      run_op(0, 16'h8000, 2'b11, 4, 0);
      run_op(0, 16'h0001, 2'b00, 1, 0);
      for (int op = 0; op < 4; op++) begin
         run_op(0, 16'h1234, 2'(op), 0, 0);
         run_op(1, 16'h1234, 2'(op), 0, 0);
      end
      run_op(1, 16'hFFFF, 2'b01, 15, 0);
      run_op(0, 16'h00F0, 2'b10, 5, 3);
      run_op(1, 16'h8421, 2'b11, 9, 3);

      // reset while an LSR by 10 is still shifting
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 16'hABCD; in_op[0] = 2'b10; in_amt[0] = 4'd10;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", in_ready[0], 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_in_ready", in_ready[0], 1);
      check("mid_rst_valid", out_valid[0], 0);
      check("mid_rst_data", out_data[0], 0);
`ifdef SHIFTER_CARRY_EN
      check("mid_rst_carry", out_carry[0], 0);
`endif
      run_op(0, 16'hABCD, 2'b10, 10, 0);

      for (int i = 0; i < 60; i++) begin
         for (int d = 0; d < 2; d++)
            run_op(d, 16'($urandom), 2'($urandom), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
